// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (8N1 / 8E1 / 8O1 style framing).
//
// Accepts a parallel byte on a DATA_VALID pulse while idle and sends it LSB-first as
// start bit, DATA_WIDTH data bits, optional parity bit and stop bit(s). Every bit lasts
// P clk cycles, where P is PRESCALE latched at accept (0 is treated as 1).
//
// Optional feature: define UART_TX_STOP2_EN to add the STOP2 input, which selects a
// double-length stop period for the frame being accepted.
//
// Ports:
//   clk        in   single clock for all logic
//   reset_n    in   asynchronous active-low reset
//   P_DATA     in   data to send, sampled on accept
//   DATA_VALID in   send request, honoured only while idle
//   PAR_EN     in   1 = insert parity bit after the data, sampled on accept
//   PAR_TYP    in   0 = even parity, 1 = odd parity, sampled on accept
//   PRESCALE   in   clk cycles per bit, sampled on accept
//   STOP2      in   (UART_TX_STOP2_EN only) 1 = two stop bit periods
//   TX_OUT     out  serial line, idle high, registered
//   busy       out  high while a frame is in progress, registered

module uart_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
`ifdef UART_TX_STOP2_EN
    input  logic                      STOP2,
`endif
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                    state;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [BitCntW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [DATA_WIDTH-1:0]     shift_nxt;
    logic                      par_bit;
    logic                      par_en_q;
    logic                      stop_second;
    logic                      stop_more;
    logic                      bit_done;

`ifdef UART_TX_STOP2_EN
    logic                      stop2_q;

    // A second stop period is still owed.
    assign stop_more = stop2_q & ~stop_second;
`else
    assign stop_more = 1'b0;
`endif

    assign shift_nxt = shift_q >> 1;
    // Last cycle of the current bit period.
    assign bit_done  = (presc_cnt == presc_q - PRESCALE_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            presc_q     <= '0;
            presc_cnt   <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            par_bit     <= 1'b0;
            par_en_q    <= 1'b0;
            stop_second <= 1'b0;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_q     <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (DATA_VALID) begin
                        shift_q     <= P_DATA;
                        par_en_q    <= PAR_EN;
                        // Even: XOR of data; odd: XNOR of data.
                        par_bit     <= (^P_DATA) ^ PAR_TYP;
                        presc_q     <= (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
                        presc_cnt   <= '0;
                        bit_cnt     <= '0;
                        stop_second <= 1'b0;
`ifdef UART_TX_STOP2_EN
                        stop2_q     <= STOP2;
`endif
                        state       <= StStart;
                        TX_OUT      <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                StStart: begin
                    if (bit_done) begin
                        presc_cnt <= '0;
                        state     <= StData;
                        TX_OUT    <= shift_q[0];
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
                    end
                end

                StData: begin
                    if (bit_done) begin
                        presc_cnt <= '0;
                        shift_q   <= shift_nxt;
                        if (bit_cnt == LastBit) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state  <= StParity;
                                TX_OUT <= par_bit;
                            end else begin
                                state  <= StStop;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BitCntW'(1);
                            TX_OUT  <= shift_nxt[0];
                        end
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
                    end
                end

                StParity: begin
                    if (bit_done) begin
                        presc_cnt <= '0;
                        state     <= StStop;
                        TX_OUT    <= 1'b1;
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
                    end
                end

                StStop: begin
                    TX_OUT <= 1'b1;
                    if (bit_done) begin
                        presc_cnt <= '0;
                        if (stop_more) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            state       <= StIdle;
                            busy        <= 1'b0;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
                    end
                end

                default: begin
                    state  <= StIdle;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle scoreboard of {TX_OUT, busy} plus frame-length checks.
module tb_uart_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       busy;
`ifdef UART_TX_STOP2_EN
    logic       stop2_drv;
`endif

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
`ifdef UART_TX_STOP2_EN
        .STOP2      (stop2_drv),
`endif
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {TX_OUT, busy} per cycle; empty queue means the line must be idle.
    logic [1:0] exp_q[$];

    int run      = 0;
    int last_run = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b10;
        check("tx_busy", {30'd0, TX_OUT, busy}, {30'd0, e});
        if (busy === 1'b1) begin
            run++;
        end else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    // Queue one idle cycle (the accept cycle) followed by the whole frame.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] presc, input logic s2);
        int   p;
        int   n_stop;
        logic par;
        p      = (presc == 6'd0) ? 1 : int'(presc);
        par    = (^d) ^ pt;
        n_stop = 1;
`ifdef UART_TX_STOP2_EN
        if (s2) n_stop = 2;
`endif
        exp_q.push_back(2'b10);
        repeat (p) exp_q.push_back(2'b01);
        for (int b = 0; b < 8; b++) begin
            repeat (p) exp_q.push_back({d[b], 1'b1});
        end
        if (pe) begin
            repeat (p) exp_q.push_back({par, 1'b1});
        end
        repeat (n_stop * p) exp_q.push_back(2'b11);
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] presc, input logic s2);
        @(posedge clk);
        #1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        PRESCALE   = presc;
`ifdef UART_TX_STOP2_EN
        stop2_drv  = s2;
`endif
        DATA_VALID = 1'b1;
        push_frame(d, pe, pt, presc, s2);
    endtask

    task automatic end_valid();
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", {31'd0, exp_q.size() != 0}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] presc;
        logic       s2;
        int         len;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        PRESCALE   = 6'd1;
`ifdef UART_TX_STOP2_EN
        stop2_drv  = 1'b0;
`endif
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 6'd1,  1'b0, 11});
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 6'd4,  1'b0, 44});
        vecs.push_back('{8'hA5, 1'b0, 1'b1, 6'd4,  1'b0, 40});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 6'd0,  1'b0, 11});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 6'd2,  1'b0, 22});
        vecs.push_back('{8'h01, 1'b0, 1'b0, 6'd63, 1'b0, 630});
`ifdef UART_TX_STOP2_EN
        vecs.push_back('{8'h00, 1'b0, 1'b0, 6'd2,  1'b1, 22});
        vecs.push_back('{8'h96, 1'b1, 1'b1, 6'd3,  1'b1, 36});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);

        foreach (vecs[i]) begin
            start_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].presc, vecs[i].s2);
            end_valid();
            drain();
            check($sformatf("frame_len_%0d", i), last_run, vecs[i].len);
        end

        // Request during a frame must be ignored.
        start_frame(8'hC3, 1'b1, 1'b0, 6'd3, 1'b0);
        end_valid();
        repeat (5) @(posedge clk);
        #1;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PRESCALE   = 6'd1;
        DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
        drain();
        check("ignored_len", last_run, 33);

        // Back-to-back with DATA_VALID held: one idle cycle between frames.
        start_frame(8'h01, 1'b0, 1'b0, 6'd1, 1'b0);
        @(posedge clk);
        #1;
        P_DATA = 8'h80;
        push_frame(8'h80, 1'b0, 1'b0, 6'd1, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
        drain();
        check("b2b_len", last_run, 10);

        // Async reset during data bit 3 (a low bit of 0x55).
        start_frame(8'h55, 1'b0, 1'b0, 6'd4, 1'b0);
        end_valid();
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_tx", {31'd0, TX_OUT}, 32'd0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        start_frame(8'hFF, 1'b1, 1'b0, 6'd3, 1'b0);
        end_valid();
        drain();
        check("post_reset_len", last_run, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter: the transmit end of the same 8N1/8E1/8O1 link our UART receiver and its parity checker terminate. It accepts a parallel byte with a valid pulse and serialises it LSB-first as start, data, optional parity and stop. Bit period is set at runtime by a prescale input. Sits between the system-side producer (register file or FIFO pop) and the TX pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of the PRESCALE input; bit period is 1 to 2^PRESCALE_WIDTH-1 clk cycles

Ports:
clk  input  1  single clock for all logic
reset_n  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel data to send, sampled on accept
DATA_VALID  input  1  request to send P_DATA; honoured only when busy=0
PAR_EN  input  1  1 = parity bit inserted after data; sampled on accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept
PRESCALE  input  PRESCALE_WIDTH  clk cycles per bit; sampled on accept; 0 treated as 1
TX_OUT  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress, registered

Behaviour:
- Reset (async, any state, including mid-frame): state=IDLE, TX_OUT=1, busy=0, all counters 0, shift register 0. Line returns high immediately on reset assertion, without glitching low.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. Accept happens when DATA_VALID=1 on a clk edge. At that edge:
  - latch P_DATA, PAR_EN, PAR_TYP and max(PRESCALE,1);
  - compute the parity bit: even = XOR of the data bits; odd = XNOR of the data bits;
  - go to START with TX_OUT=0 and busy=1. Both are visible the cycle after the accepting edge.
- Bit timing: a prescale counter runs 0..P-1, where P is the latched prescale. Every bit is held for exactly P clk cycles. The state advances on the edge where the counter equals P-1 and the counter wraps to 0.
- START: TX_OUT=0 for P cycles, then go to DATA.
- DATA: TX_OUT = shift register LSB. The register shifts right at the end of each bit. A bit counter runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if PAR_EN was latched high, otherwise go to STOP.
- PARITY: TX_OUT = latched parity bit for P cycles, then go to STOP.
- STOP: TX_OUT=1 for P cycles, then go to IDLE with busy=0.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × P cycles, measured from the first low cycle to busy falling.
- DATA_VALID while busy=1 is ignored. It is not queued, and input changes mid-frame have no effect.
- Back-to-back frames: DATA_VALID held high gives exactly one IDLE clk between the last STOP cycle and the next START cycle.
- TX_OUT and busy come directly from flops, with no combinational path from inputs.

Optional Feature:
Macro UART_TX_STOP2_EN.
- Defined: adds input STOP2 (1 bit), sampled on accept. When it is 1, STOP lasts 2×P cycles, and the frame length grows by P.
- Undefined: the STOP2 port does not exist and every frame has exactly one stop bit of P cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Reset values: hold reset_n=0 -> TX_OUT=1, busy=0. Release reset with DATA_VALID=0 for 20 clk -> TX_OUT stays 1.
- Even parity, P=1: PRESCALE=1, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, pulse DATA_VALID -> TX_OUT sequence over 11 cycles is 0,1,0,1,0,0,1,0,1,0,1, busy high for exactly 11 cycles.
- Odd parity, no-parity, P=4:
  - PRESCALE=4, PAR_TYP=1, P_DATA=0xA5 -> parity bit 1, each bit held 4 cycles, 44-cycle frame.
  - Repeat with PAR_EN=0 -> 40-cycle frame with no parity slot.
- Busy and back-to-back: during a frame, pulse DATA_VALID with P_DATA=0x3C -> ignored, the original byte completes unchanged. Then hold DATA_VALID=1 with 0x01 then 0x80 -> two frames separated by exactly one idle-high cycle.
- Reset mid-frame and PRESCALE=0:
  - Assert reset_n=0 during DATA bit 3 -> TX_OUT=1 and busy=0 asynchronously; the next accepted byte 0xFF transmits a full, correct frame.
  - PRESCALE=0 -> behaves as P=1.
- UART_TX_STOP2_EN build: STOP2=1, P=2, PAR_EN=0, P_DATA=0x00 -> TX_OUT low for 18 cycles, then high for 4 cycles before busy falls.
